ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single BRAMI32 port between the CPU/DMA path (read/write) and NDMA
//  peripheral DMA read channels (e.g. Buzzer16 sample fetch, future G10k fetch).
//  Serialises one transaction at a time; CPU has priority, bounded by a starvation limit.
//  DMA channels are served round-robin. Sits between DMA/peripherals and BRAMI32.
// PARAMETERS
//  AW          15  RAM word-address width
//  DW          32  RAM data width
//  NDMA        2   number of DMA read channels (1..4)
//  STARVE_MAX  8   max consecutive CPU grants while any dma_req is pending
//  TIMEOUT     255 watchdog limit in cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1        system clock (iclk domain)
//  rst           in   1        asynchronous reset, active high
//  cpu_req       in   1        CPU request; held until cpu_rdy
//  cpu_we        in   1        1 = write, 0 = read; sampled at grant
//  cpu_addr      in   AW       CPU address; sampled at grant
//  cpu_din       in   DW       CPU write data; sampled at grant
//  cpu_dout      out  DW       read data; valid with cpu_rdy, held until next CPU read
//  cpu_rdy       out  1        one-cycle completion pulse
//  dma_req       in   NDMA     per-channel read request; held until its dma_rdy bit
//  dma_addr      in   NDMA*AW  channel i address in bits [i*AW +: AW]
//  dma_dout      out  DW       shared read data; valid with any dma_rdy bit
//  dma_rdy       out  NDMA     one-hot, one-cycle completion pulse
//  ram_addr      out  AW       to BRAMI32 addr; held for the whole transaction
//  ram_din       out  DW       to BRAMI32 din
//  ram_we        out  1        to BRAMI32 we; high throughout WRITE
//  ram_start     out  1        to startReadRAM; one-cycle pulse on READ entry
//  ram_out       in   DW       from BRAMI32 out
//  ram_read_rdy  in   1        from readRdyRAM
//  ram_save_rdy  in   1        from saveRdyRAM
//  busy          out  1        high in every state except IDLE
//  err           out  1        sticky watchdog flag (0 when ARB_TIMEOUT_EN undefined)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = NDMA-1 (ch0 wins first); starve cnt 0.
//  FSM: IDLE -> READ | WRITE -> DONE -> IDLE. Exactly one transaction in flight.
//  IDLE: arbitrate on the current cycle's requests; latch grantee, addr, data, we.
//   - CPU wins if cpu_req && (no dma_req || starve < STARVE_MAX).
//   - Otherwise the first set dma_req at or after rr+1 (mod NDMA) wins; rr <= winner.
//   - Starve cnt: +1 (saturating) on a CPU grant while any dma_req is set; 0 on a DMA grant
//     or on a CPU grant with no dma_req pending.
//   - No request: stay IDLE; ram_* outputs hold their last value, ram_we/ram_start = 0.
//  READ: ram_start=1 on the first READ cycle only. Wait for ram_read_rdy (may arrive the
//   very next cycle). On sampling it, latch ram_out into cpu_dout or dma_dout; go to DONE.
//  WRITE (CPU only): ram_we=1 until ram_save_rdy is sampled; then go to DONE.
//  DONE: pulse cpu_rdy or dma_rdy[grantee] for exactly 1 cycle; next state IDLE.
//   A requester that is still asserting req in DONE is not re-granted in that same cycle.
//  Best-case read: req at cycle 0, ram_start at cycle 1, read_rdy at cycle 1, rdy at cycle 2.
//  ram_read_rdy/ram_save_rdy are ignored outside the matching state.
//  A req dropped after grant does not abort the transaction; the rdy pulse is still issued.
//  A req dropped before grant is never served.
//  Async rst mid-transaction: immediate return to IDLE; no rdy pulse is issued.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: in READ/WRITE, count cycles; when the count reaches TIMEOUT
//   without a RAM rdy, set err (sticky until rst), drop ram_we, go to DONE, and pulse the
//   grantee's rdy with data = 0 (no deadlock).
//  ARB_TIMEOUT_EN undefined: no counter; waits indefinitely; err tied 0.
// TESTING
//  1 CPU read 0x0010, RAM returns 0xDEADBEEF 1 cycle after start -> cpu_rdy at cycle 2,
//    cpu_dout=0xDEADBEEF, ram_start single pulse.
//  2 CPU write 0x7FFF data 0x12345678, save_rdy after 3 cycles -> ram_we high 3 cycles,
//    then cpu_rdy 1 pulse.
//  3 dma_req=2'b11 held from reset -> grants alternate ch0, ch1, ch0; dma_rdy
//    one-hot 01, 10, 01.
//  4 cpu_req and dma_req[0] held, STARVE_MAX=8 -> 8 CPU grants, then one ch0 grant, repeating.
//  5 rst during READ before read_rdy -> busy=0 next cycle; no rdy pulse; the next req is
//    served normally.
//  6 ARB_TIMEOUT_EN, TIMEOUT=16, RAM silent -> err=1 and cpu_rdy pulse with dout 0
//    ~17 cycles after start.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port RAM arbiter: CPU read/write plus round-robin DMA read channels.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_port_arbiter #(
  parameter int AW         = 15,
  parameter int DW         = 32,
  parameter int NDMA       = 2,
  parameter int STARVE_MAX = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_din,
  output logic [DW-1:0]      cpu_dout,
  output logic               cpu_rdy,
  input  logic [NDMA-1:0]    dma_req,
  input  logic [NDMA*AW-1:0] dma_addr,
  output logic [DW-1:0]      dma_dout,
  output logic [NDMA-1:0]    dma_rdy,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_din,
  output logic               ram_we,
  output logic               ram_start,
  input  logic [DW-1:0]      ram_out,
  input  logic               ram_read_rdy,
  input  logic               ram_save_rdy,
  output logic               busy,
  output logic               err
);

  localparam int RRW = (NDMA > 1) ? $clog2(NDMA) : 1;
  localparam int SW  = $clog2(STARVE_MAX + 1);
  localparam logic [NDMA-1:0] DMA_ONE = NDMA'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t         state;
  logic [RRW-1:0] rr;
  logic [RRW-1:0] g_ch;
  logic [RRW-1:0] dma_win;
  logic           g_cpu;
  logic [SW-1:0]  starve;
  logic           any_dma;
  logic           cpu_win;
  logic           tmo;

  assign busy = (state != S_IDLE);

  always_comb begin
    any_dma = |dma_req;
    cpu_win = cpu_req && (!any_dma || (starve < SW'(STARVE_MAX)));
  end

  // Scan downwards so the channel closest after rr overwrites any later one.
  always_comb begin
    dma_win = rr;
    for (int k = NDMA; k >= 1; k--) begin
      if (dma_req[(int'(rr) + k) % NDMA]) dma_win = RRW'((int'(rr) + k) % NDMA);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          waiting;
  logic          err_q;

  assign waiting = ((state == S_READ) && !ram_read_rdy) || ((state == S_WRITE) && !ram_save_rdy);
  assign tmo     = waiting && (tcnt == TW'(TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else if (waiting && !tmo) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr        <= RRW'(NDMA - 1);
      g_ch      <= '0;
      g_cpu     <= 1'b0;
      starve    <= '0;
      cpu_dout  <= '0;
      cpu_rdy   <= 1'b0;
      dma_dout  <= '0;
      dma_rdy   <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      ram_start <= 1'b0;
    end else begin
      ram_start <= 1'b0;
      cpu_rdy   <= 1'b0;
      dma_rdy   <= '0;
      case (state)
        S_IDLE: begin
          if (cpu_win) begin
            g_cpu    <= 1'b1;
            ram_addr <= cpu_addr;
            ram_din  <= cpu_din;
            if (!any_dma) starve <= '0;
            else if (starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
            if (cpu_we) begin
              ram_we <= 1'b1;
              state  <= S_WRITE;
            end else begin
              ram_start <= 1'b1;
              state     <= S_READ;
            end
          end else if (any_dma) begin
            g_cpu     <= 1'b0;
            g_ch      <= dma_win;
            rr        <= dma_win;
            starve    <= '0;
            ram_addr  <= dma_addr[int'(dma_win)*AW +: AW];
            ram_start <= 1'b1;
            state     <= S_READ;
          end
        end
        S_READ: begin
          // A watchdog expiry completes the read with zero data.
          if (ram_read_rdy || tmo) begin
            state <= S_DONE;
            if (g_cpu) begin
              cpu_dout <= ram_read_rdy ? ram_out : '0;
              cpu_rdy  <= 1'b1;
            end else begin
              dma_dout <= ram_read_rdy ? ram_out : '0;
              dma_rdy  <= DMA_ONE << g_ch;
            end
          end
        end
        S_WRITE: begin
          if (ram_save_rdy || tmo) begin
            ram_we  <= 1'b0;
            cpu_rdy <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter.
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [31:0] cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_rdy;
  logic [1:0]  dma_req = '0;
  logic [29:0] dma_addr = '0;
  logic [31:0] dma_dout;
  logic [1:0]  dma_rdy;
  logic [14:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic        ram_start;
  logic [31:0] ram_out = '0;
  logic        ram_read_rdy = 1'b0;
  logic        ram_save_rdy = 1'b0;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  // RAM responder configuration
  bit          rd_en = 1'b1;
  int          rd_lat = 1;
  int          wr_lat = 3;
  bit          rd_fixed_en = 1'b1;
  logic [31:0] rd_fixed = 32'hDEADBEEF;
  int          rcnt = 0;
  int          wcnt = 0;

  ram_port_arbiter #(.AW(15), .DW(32), .NDMA(2), .STARVE_MAX(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_rdy(dma_rdy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_start(ram_start),
    .ram_out(ram_out), .ram_read_rdy(ram_read_rdy), .ram_save_rdy(ram_save_rdy),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_start) rcnt = 1;
    else if (rcnt != 0 && rcnt <= rd_lat) rcnt = rcnt + 1;
    else rcnt = 0;
    ram_read_rdy = rd_en && (rcnt != 0) && (rcnt == rd_lat);
    ram_out = rd_fixed_en ? rd_fixed : (32'hA500_0000 | {17'b0, ram_addr});
    if (ram_we) wcnt = wcnt + 1;
    else wcnt = 0;
    ram_save_rdy = (wcnt == wr_lat);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (cpu_rdy || dma_rdy != 2'b00) got = 1'b1;
    end
  endtask

  initial begin
    bit got;
    bit seen;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_rdy", cpu_rdy, 0);
    chk("rst_dma_rdy", dma_rdy, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_start", ram_start, 0);
    chk("rst_err", err, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_ram_addr", ram_addr, 0);
    rst = 1'b0;

    // 1: best-case CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    @(negedge clk);
    chk("t1_start", ram_start, 1);
    chk("t1_addr", ram_addr, 15'h0010);
    chk("t1_busy", busy, 1);
    chk("t1_rdy_early", cpu_rdy, 0);
    @(negedge clk);
    chk("t1_rdy", cpu_rdy, 1);
    chk("t1_dout", cpu_dout, 32'hDEADBEEF);
    chk("t1_start_single", ram_start, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t1_rdy_pulse", cpu_rdy, 0);
    chk("t1_idle", busy, 0);

    // 2: CPU write, save_rdy on the third write cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h7FFF; cpu_din = 32'h12345678;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t2_we", ram_we, 1);
      chk("t2_rdy_early", cpu_rdy, 0);
      chk("t2_no_start", ram_start, 0);
    end
    chk("t2_addr", ram_addr, 15'h7FFF);
    chk("t2_din", ram_din, 32'h12345678);
    @(negedge clk);
    chk("t2_we_drop", ram_we, 0);
    chk("t2_rdy", cpu_rdy, 1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("t2_rdy_pulse", cpu_rdy, 0);
    chk("t2_dout_held", cpu_dout, 32'hDEADBEEF);

    // 3: both DMA channels held from reset alternate ch0, ch1, ch0
    rd_fixed_en = 1'b0;
    rst = 1'b1; dma_req = 2'b11; dma_addr = {15'h0200, 15'h0100};
    @(negedge clk);
    rst = 1'b0;
    wait_done(12, got);
    chk("t3_wait0", got, 1);
    chk("t3_rdy0", {cpu_rdy, dma_rdy}, 3'b001);
    chk("t3_dout0", dma_dout, 32'hA500_0100);
    wait_done(12, got);
    chk("t3_wait1", got, 1);
    chk("t3_rdy1", {cpu_rdy, dma_rdy}, 3'b010);
    chk("t3_dout1", dma_dout, 32'hA500_0200);
    wait_done(12, got);
    chk("t3_wait2", got, 1);
    chk("t3_rdy2", {cpu_rdy, dma_rdy}, 3'b001);
    chk("t3_dout2", dma_dout, 32'hA500_0100);

    // 4: CPU and ch0 held: 8 CPU grants, then one ch0 grant, repeating
    dma_req = 2'b01; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0040;
    for (int n = 0; n < 18; n++) begin
      wait_done(12, got);
      chk("t4_wait", got, 1);
      chk($sformatf("t4_grant%0d", n), {cpu_rdy, dma_rdy}, (n % 9 == 8) ? 3'b001 : 3'b100);
      if (n == 0) chk("t4_cpu_dout", cpu_dout, 32'hA500_0040);
    end
    cpu_req = 1'b0; dma_req = 2'b00;
    repeat (3) @(negedge clk);
    chk("t4_idle", busy, 0);

    // 5: async reset during READ before read_rdy
    rd_en = 1'b0;
    cpu_req = 1'b1; cpu_addr = 15'h0055;
    @(negedge clk);
    chk("t5_start", ram_start, 1);
    chk("t5_busy", busy, 1);
    @(negedge clk);
    cpu_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_busy_async", busy, 0);
    chk("t5_rdy_async", cpu_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_dout_clr", cpu_dout, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_rdy || dma_rdy != 2'b00 || busy) seen = 1'b1;
    end
    chk("t5_no_rdy", seen, 0);
    rd_en = 1'b1;
    cpu_req = 1'b1; cpu_addr = 15'h0066;
    wait_done(12, got);
    chk("t5_wait", got, 1);
    chk("t5_rdy", cpu_rdy, 1);
    chk("t5_dout", cpu_dout, 32'hA500_0066);
    cpu_req = 1'b0;
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // 6: silent RAM, watchdog completes the read with zero data
    rd_en = 1'b0;
    cpu_req = 1'b1; cpu_addr = 15'h0077;
    wait_done(40, got);
    chk("t6_wait", got, 1);
    chk("t6_rdy", cpu_rdy, 1);
    chk("t6_err", err, 1);
    chk("t6_dout", cpu_dout, 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
